ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//   EX-stage consumer of the ID/EX pipeline register outputs: iterative 32-bit multiply/divide unit.
//   Takes forwarded operands, runs mult/multu/div/divu at one bit per cycle, and holds results in HI/LO.
//   While busy it drives stall to freeze PC, IF/ID and ID/EX, so the issuing instruction waits in ID/EX.
// PARAMETERS
//   WIDTH  32  operand width; iteration count = WIDTH
// PORTS
//   clk    in   1      clock, rising edge
//   rst    in   1      reset, synchronous, active-low
//   start  in   1      issue request from the ID/EX control field; sampled only in IDLE
//   op     in   2      00 mult, 01 multu, 10 div, 11 divu; sampled with start
//   flush  in   1      abort in-flight op (branch/exception flush)
//   a      in   WIDTH  operand rs (post-forwarding), sampled with start
//   b      in   WIDTH  operand rt (post-forwarding), sampled with start
//   busy   out  1      registered; high when state != IDLE
//   stall  out  1      combinational: busy | (start & state==IDLE & ~flush)
//   done   out  1      registered one-cycle pulse when hi/lo update
//   hi     out  WIDTH  HI register: product[63:32] or remainder
//   lo     out  WIDTH  LO register: product[31:0] or quotient
// BEHAVIOUR
//   Reset (rst==0 at an edge): state=IDLE, busy=0, done=0, hi=0, lo=0, internal regs cleared.
//     Reset dominates flush and start; a reset mid-operation discards the operation.
//   FSM states: IDLE, CALC, SIGN.
//   IDLE: start=1 & flush=0 at edge E0 -> latch op and |a|,|b| (abs only for signed ops),
//     latch sign_a, sign_b, clear counter -> CALC.
//   CALC: one iteration per edge, WIDTH edges (E1..E_WIDTH). Counter runs 0..WIDTH-1, wrapping to 0 on exit.
//     Mul uses shift-add over a 2*WIDTH accumulator.
//     Div uses restoring shift-subtract with a WIDTH+1-bit partial remainder.
//     After the last iteration -> SIGN.
//   SIGN: edge E_{WIDTH+1} writes hi/lo, sets done=1 for one cycle, and returns to IDLE.
//     Signed mult: negate the 64-bit product if sign_a^sign_b.
//     Signed div: quotient negated if sign_a^sign_b; remainder takes the sign of a (sign_a).
//     -2^31 / -1 -> lo=32'h80000000, hi=0, with no trap.
//   Latency: done is high in the cycle after edge WIDTH+1 (34 edges after start for WIDTH=32).
//     stall is low in that cycle, so the instruction leaves ID/EX exactly once.
//   Divide by zero: still runs the full WIDTH iterations; result lo=all ones, hi=a (unsigned magnitude
//     path, then sign fix), so divu x/0 gives hi=x, lo=FFFFFFFF. No exception.
//   flush=1 in CALC or SIGN -> IDLE next edge; hi/lo unchanged, done=0. flush in IDLE blocks start.
//   start while busy is ignored; the issuer is held by stall anyway.
//   start in the same cycle as done (back-to-back): accepted, because state==IDLE then.
//   hi/lo change only on the SIGN edge or on reset; readable at any time (mfhi/mflo path).
//   Operand width rules: all internal adds are WIDTH+1 bits; no result truncation beyond hi/lo.
// TESTING
//   mult 7 * -3 -> after 34 edges done=1, hi=FFFFFFFF, lo=FFFFFFEB; stall high for exactly 34 cycles.
//   multu FFFFFFFF * 2 -> hi=00000001, lo=FFFFFFFE; mult of the same operands -> hi=FFFFFFFF, lo=FFFFFFFE.
//   div -7 / 2 -> lo=FFFFFFFD, hi=FFFFFFFF; divu 100 / 7 -> lo=0000000E, hi=00000002.
//   divu 5 / 0 -> lo=FFFFFFFF, hi=00000005; div 80000000 / FFFFFFFF -> lo=80000000, hi=0.
//   flush at CALC iteration 10 -> busy=0 next cycle, hi/lo keep their prior values, no done pulse.
//   rst=0 at iteration 20, then restart -> hi=lo=0 after reset; new op completes with correct result.
//   start held high through done -> second op accepted in the done cycle, second done 34 edges later.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative WIDTH-bit multiply/divide unit for the EX stage.
// Runs mult/multu/div/divu at one bit per cycle on magnitudes, fixes signs in
// a final cycle, and holds the results in HI/LO. The unit stalls the front of
// the pipeline while an operation is in flight.
//
// Handshake: the issuer presents start/op/a/b and holds them while stall is
// high. The operation is accepted on the first edge where the unit is IDLE and
// flush is low. stall drops in the cycle where done pulses, so the issuing
// instruction leaves ID/EX exactly once. flush aborts any in-flight operation
// and leaves hi/lo untouched.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic               sign_a;
  logic               sign_b;
  // Multiply: {upper accumulator, shifting multiplier}. Divide: low half is
  // the dividend shifting out while quotient bits shift in.
  logic [2*WIDTH-1:0] acc;
  // Multiplicand magnitude for mult, divisor magnitude for div.
  logic [WIDTH-1:0]   opb;
  logic [WIDTH:0]     rem;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes (op[0]==0 means signed) plus one iteration step and sign fix-up.
  always_comb begin
    a_neg     = ~op[0] & a[WIDTH-1];
    b_neg     = ~op[0] & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
    div_trial = div_shift - {1'b0, opb};
    prod_fix  = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    quo_fix   = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix   = sign_a ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
  end

  assign stall     = busy | (start & (state == IDLE) & ~flush);
  assign dbg_state = state;

  // Control FSM, iteration datapath and HI/LO result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      acc    <= '0;
      opb    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q   <= op;
            sign_a <= a_neg;
            sign_b <= b_neg;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
            opb    <= op[1] ? b_mag : a_mag;
            rem    <= '0;
            cnt    <= '0;
            state  <= CALC;
            busy   <= 1'b1;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            if (op_q[1]) begin
              // Restoring divide: keep the trial remainder only if it did not go negative.
              rem            <= div_trial[WIDTH] ? div_shift : div_trial;
              acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_trial[WIDTH]};
            end else begin
              acc <= {mul_sum, acc[WIDTH-1:1]};
            end
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= SIGN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SIGN: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (op_q[1]) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: hand-computed vectors for each op,
// latency/stall accounting, flush, mid-operation reset and back-to-back issue.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .flush(flush),
    .a(a), .b(b), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op at posedge+1, count edges until done and cycles with stall high.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int edges;
    int nst;
    bit got;
    start = 1'b1; op = o; a = x; b = y;
    edges = 0; nst = 0; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      if (stall) nst++;
      @(posedge clk); #1;
      edges++;
      start = 1'b0;
    end
    chk({tag, " done_seen"}, 64'(got), 64'd1);
    chk({tag, " edges"}, 64'(edges), 64'd34);
    chk({tag, " stall_cycles"}, 64'(nst), 64'd34);
    chk({tag, " stall_in_done"}, 64'(stall), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
    @(posedge clk); #1;
  endtask

  // Wait for done with a bound; returns the number of edges observed.
  task automatic wait_done(output int edges, output bit got);
    edges = 1; got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
      @(posedge clk); #1;
      edges++;
    end
  endtask

  initial begin
    int edges;
    int pulses;
    bit got;
    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst stall", 64'(stall), 64'd0);
    chk("rst state", 64'(dbg_state), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op("mult 7*-3", 2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op("multu ffffffff*2", 2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    run_op("mult ffffffff*2", 2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
    run_op("div min/-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);

    // flush at iteration 10
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush pre state", 64'(dbg_state), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    chk("flush stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush done", 64'(done), 64'd0);
    chk("flush hi", 64'(hi), 64'd2);
    chk("flush lo", 64'(lo), 64'hE);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("flush no_done", 64'(pulses), 64'd0);

    // flush in IDLE blocks start
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("idle flush stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    chk("idle flush busy", 64'(busy), 64'd0);
    start = 1'b0; flush = 1'b0;

    // reset at iteration 20 discards the op
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'hFFFFFFFD;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst hi", 64'(hi), 64'd0);
    chk("midrst lo", 64'(lo), 64'd0);
    chk("midrst state", 64'(dbg_state), 64'd0);
    run_op("after rst divu 100/7", 2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);

    // back-to-back: start held through done; operands changed while busy are ignored
    start = 1'b1; op = 2'b00; a = 32'd7; b = 32'hFFFFFFFD;
    @(posedge clk); #1;
    op = 2'b10; a = 32'hFFFFFFF9; b = 32'd2;
    wait_done(edges, got);
    chk("b2b first done_seen", 64'(got), 64'd1);
    chk("b2b first edges", 64'(edges), 64'd34);
    chk("b2b first hi", 64'(hi), 64'hFFFFFFFF);
    chk("b2b first lo", 64'(lo), 64'hFFFFFFEB);
    chk("b2b stall in done", 64'(stall), 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b accepted busy", 64'(busy), 64'd1);
    wait_done(edges, got);
    chk("b2b second done_seen", 64'(got), 64'd1);
    chk("b2b second edges", 64'(edges), 64'd34);
    chk("b2b second hi", 64'(hi), 64'hFFFFFFFF);
    chk("b2b second lo", 64'(lo), 64'hFFFFFFFD);
    @(posedge clk); #1;
    chk("b2b done one pulse", 64'(done), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
